// File: rtl/pe_spad_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : pe_spad_loader_if
//  Description : Bundles the loader's two upstream valid/ready pixel sources
//                and the PE scratchpad write ports into one interface.
//                master : the loader (consumes sources, drives spad writes)
//                slave  : the surroundings (sources + PE)
//  Signals     : flt_data/flt_valid/flt_ready      filter source stream
//                ifm_data/ifm_valid/ifm_ready      ifmap source stream
//                filter_pixel/wr_filter/filter_spad_full  PE filter spad port
//                ifmap_pixel/wr_ifmap/ifmap_spad_full     PE ifmap spad port
//  Revision    : 1.0 - initial release
// ============================================================================
interface pe_spad_loader_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] flt_data;
  logic                  flt_valid;
  logic                  flt_ready;
  logic [DATA_WIDTH-1:0] ifm_data;
  logic                  ifm_valid;
  logic                  ifm_ready;
  logic [DATA_WIDTH-1:0] filter_pixel;
  logic                  wr_filter;
  logic                  filter_spad_full;
  logic [DATA_WIDTH-1:0] ifmap_pixel;
  logic                  wr_ifmap;
  logic                  ifmap_spad_full;

  modport master (
    input  flt_data, flt_valid,
    output flt_ready,
    input  ifm_data, ifm_valid,
    output ifm_ready,
    output filter_pixel, wr_filter,
    input  filter_spad_full,
    output ifmap_pixel, wr_ifmap,
    input  ifmap_spad_full
  );

  modport slave (
    output flt_data, flt_valid,
    input  flt_ready,
    output ifm_data, ifm_valid,
    input  ifm_ready,
    input  filter_pixel, wr_filter,
    output filter_spad_full,
    input  ifmap_pixel, wr_ifmap,
    output ifmap_spad_full
  );
endinterface
`default_nettype wire

// File: rtl/pe_spad_loader.sv
`default_nettype none
// ============================================================================
//  Module      : pe_spad_loader
//  Description : Write-side source for one PE. Streams a filter block
//                (p*q*S pixels), then the first ifmap window (q*S pixels),
//                then F-1 sliding updates of U*q pixels each, from two
//                valid/ready sources into the PE scratchpad write ports.
//                The PE full flags are the only backpressure.
//  Ports       : clk, reset      clock, synchronous active-high reset
//                configure       latch S,F,U,p,q (ignored while busy)
//                S,F,U,p,q       filter width, ofmap width, stride,
//                                filters/PE, channels/PE
//                start           begin one pass (ignored while busy)
//                busy            high in every state but IDLE
//                done            one-cycle pulse after the last ifmap write
//                bus             source streams + PE spad write ports
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_spad_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int S_WIDTH    = 5,
  parameter int F_WIDTH    = 6,
  parameter int U_WIDTH    = 3,
  parameter int P_WIDTH    = 5,
  parameter int Q_WIDTH    = 3
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               configure,
  input  wire logic [S_WIDTH-1:0] S,
  input  wire logic [F_WIDTH-1:0] F,
  input  wire logic [U_WIDTH-1:0] U,
  input  wire logic [P_WIDTH-1:0] p,
  input  wire logic [Q_WIDTH-1:0] q,
  input  wire logic               start,
  output logic                    busy,
  output logic                    done,
  pe_spad_loader_if.master        bus
);

  // Derived-count widths follow the product of the config field widths.
  localparam int NF_W = P_WIDTH + Q_WIDTH + S_WIDTH;
  localparam int N0_W = Q_WIDTH + S_WIDTH;
  localparam int NU_W = U_WIDTH + Q_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_FLT  = 3'd1,
    ST_IFM_FIRST = 3'd2,
    ST_IFM_SLIDE = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  state_t state, state_n;

  logic [S_WIDTH-1:0] cfg_s;
  logic [F_WIDTH-1:0] cfg_f;
  logic [U_WIDTH-1:0] cfg_u;
  logic [P_WIDTH-1:0] cfg_p;
  logic [Q_WIDTH-1:0] cfg_q;

  logic [NF_W-1:0]    cnt, cnt_n, cnt_inc;
  logic [F_WIDTH-1:0] win, win_n, win_inc;

  logic [NF_W-1:0]    nf;
  logic [N0_W-1:0]    n0;
  logic [NU_W-1:0]    nu;
  logic               ifm_en;
  logic               wr_f;
  logic               wr_i;

  // --------------------------------------------------------------------------
  // Configuration registers: only writable while idle so an in-flight pass
  // keeps the counts it started with.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_s <= '0;
      cfg_f <= '0;
      cfg_u <= '0;
      cfg_p <= '0;
      cfg_q <= '0;
    end else if (configure && (state == ST_IDLE)) begin
      cfg_s <= S;
      cfg_f <= F;
      cfg_u <= U;
      cfg_p <= p;
      cfg_q <= q;
    end
  end

  assign nf = NF_W'(cfg_p) * NF_W'(cfg_q) * NF_W'(cfg_s);
  assign n0 = N0_W'(cfg_q) * N0_W'(cfg_s);
  assign nu = NU_W'(cfg_u) * NU_W'(cfg_q);

  // Both ifmap phases are skipped when either the window or the row is empty.
  assign ifm_en = (n0 != '0) && (cfg_f != '0);

  // --------------------------------------------------------------------------
  // Transfer rule. Gating with reset keeps the abort cycle itself write-free.
  // --------------------------------------------------------------------------
  assign wr_f = ~reset & (state == ST_LOAD_FLT) & bus.flt_valid & ~bus.filter_spad_full;
  assign wr_i = ~reset & ((state == ST_IFM_FIRST) || (state == ST_IFM_SLIDE))
              & bus.ifm_valid & ~bus.ifmap_spad_full;

  assign bus.wr_filter    = wr_f;
  assign bus.flt_ready    = wr_f;
  assign bus.wr_ifmap     = wr_i;
  assign bus.ifm_ready    = wr_i;
  assign bus.filter_pixel = reset ? {DATA_WIDTH{1'b0}} : bus.flt_data;
  assign bus.ifmap_pixel  = reset ? {DATA_WIDTH{1'b0}} : bus.ifm_data;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  assign cnt_inc = cnt + NF_W'(1);
  assign win_inc = win + F_WIDTH'(1);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      win   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      win   <= win_n;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and counters. One shared pixel counter serves all phases
  // because the phases never overlap.
  // --------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    win_n   = win;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          cnt_n = '0;
          win_n = '0;
          if (nf != '0)  state_n = ST_LOAD_FLT;
          else if (ifm_en) state_n = ST_IFM_FIRST;
          else           state_n = ST_DONE;
        end
      end
      ST_LOAD_FLT: begin
        if (wr_f) begin
          if (cnt_inc == nf) begin
            cnt_n   = '0;
            state_n = ifm_en ? ST_IFM_FIRST : ST_DONE;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      ST_IFM_FIRST: begin
        if (wr_i) begin
          if (cnt_inc == NF_W'(n0)) begin
            cnt_n = '0;
            win_n = F_WIDTH'(1);
            // A zero-length slide (U==0) has nothing to load, so it ends here.
            if ((cfg_f > F_WIDTH'(1)) && (nu != '0)) state_n = ST_IFM_SLIDE;
            else                                     state_n = ST_DONE;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      ST_IFM_SLIDE: begin
        if (wr_i) begin
          if (cnt_inc == NF_W'(nu)) begin
            cnt_n = '0;
            win_n = win_inc;
            if (win_inc == cfg_f) state_n = ST_DONE;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_spad_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_spad_loader
//  Description : Self-checking bench for pe_spad_loader. A pass-level model
//                (remaining filter/ifmap pixel budgets, expected data order)
//                is checked against the DUT every cycle, and directed
//                scenarios pin totals and pass lengths with literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_spad_loader;

  localparam int DW = 16;

  logic       clk;
  logic       reset;
  logic       configure;
  logic [4:0] cfg_s;
  logic [5:0] cfg_f;
  logic [2:0] cfg_u;
  logic [4:0] cfg_p;
  logic [2:0] cfg_q;
  logic       start;
  logic       busy;
  logic       done;

  pe_spad_loader_if #(.DATA_WIDTH(DW)) bus ();

  pe_spad_loader #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .configure (configure),
    .S         (cfg_s),
    .F         (cfg_f),
    .U         (cfg_u),
    .p         (cfg_p),
    .q         (cfg_q),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Source state
  int   flt_idx = 0;
  int   ifm_idx = 0;
  bit   flt_fire = 0;
  bit   ifm_fire = 0;
  bit   ifm_vmode = 0;

  // Model state: 0 idle, 1 transferring, 2 done cycle
  int   m_state = 0;
  int   rem_f = 0, rem_i = 0;
  int   m_fw = 0, m_iw = 0;
  int   mS = 0, mF = 0, mU = 0, mp = 0, mq = 0;
  bit   chk_en = 0;

  // Per-pass statistics from the DUT
  int   tot_wf = 0, tot_wi = 0, busy_cyc = 0, done_cnt = 0;

  // Sources: advance after a handshake seen on the previous cycle.
  initial begin
    bus.flt_data  = 16'h1000;
    bus.flt_valid = 1'b1;
    bus.ifm_data  = 16'h2000;
    bus.ifm_valid = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (flt_fire) flt_idx++;
      if (ifm_fire) ifm_idx++;
      flt_fire = 0;
      ifm_fire = 0;
      bus.flt_data  = 16'h1000 + 16'(flt_idx);
      bus.ifm_data  = 16'h2000 + 16'(ifm_idx);
      bus.flt_valid = 1'b1;
      bus.ifm_valid = ifm_vmode ? ~bus.ifm_valid : 1'b1;
    end
  end

  // Compare process: outputs are checked at the falling edge, then the
  // model advances using the same input values the DUT samples next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        bit run, exp_wf, exp_wi;
        run    = (m_state == 1) && !reset;
        exp_wf = run && (rem_f > 0) && bus.flt_valid && !bus.filter_spad_full;
        exp_wi = run && (rem_f == 0) && (rem_i > 0) && bus.ifm_valid && !bus.ifmap_spad_full;

        chk("busy",      32'(busy),          32'(m_state != 0));
        chk("done",      32'(done),          32'(m_state == 2));
        chk("wr_filter", 32'(bus.wr_filter), 32'(exp_wf));
        chk("flt_ready", 32'(bus.flt_ready), 32'(exp_wf));
        chk("wr_ifmap",  32'(bus.wr_ifmap),  32'(exp_wi));
        chk("ifm_ready", 32'(bus.ifm_ready), 32'(exp_wi));
        chk("filter_pixel", 32'(bus.filter_pixel), reset ? 32'd0 : 32'(bus.flt_data));
        chk("ifmap_pixel",  32'(bus.ifmap_pixel),  reset ? 32'd0 : 32'(bus.ifm_data));
        if (exp_wf) chk("flt_order", 32'(bus.filter_pixel), 32'(16'h1000 + 16'(m_fw)));
        if (exp_wi) chk("ifm_order", 32'(bus.ifmap_pixel),  32'(16'h2000 + 16'(m_iw)));

        if (bus.wr_filter) tot_wf++;
        if (bus.wr_ifmap)  tot_wi++;
        if (busy)          busy_cyc++;
        if (done)          done_cnt++;
        flt_fire = bus.flt_ready;
        ifm_fire = bus.ifm_ready;

        if (reset) begin
          m_state = 0; rem_f = 0; rem_i = 0;
          mS = 0; mF = 0; mU = 0; mp = 0; mq = 0;
        end else begin
          case (m_state)
            0: begin
              if (start) begin
                int n0;
                rem_f = mp * mq * mS;
                n0    = mq * mS;
                rem_i = (n0 == 0 || mF == 0) ? 0 : n0 + (mF - 1) * (mU * mq);
                m_state = (rem_f + rem_i == 0) ? 2 : 1;
              end
              if (configure) begin
                mS = int'(cfg_s); mF = int'(cfg_f); mU = int'(cfg_u);
                mp = int'(cfg_p); mq = int'(cfg_q);
              end
            end
            1: begin
              if (exp_wf) begin rem_f--; m_fw++; end
              if (exp_wi) begin rem_i--; m_iw++; end
              if (rem_f == 0 && rem_i == 0) m_state = 2;
            end
            default: m_state = 0;
          endcase
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_config(input int s, input int f, input int u, input int pp, input int qq);
    cfg_s = 5'(s); cfg_f = 6'(f); cfg_u = 3'(u); cfg_p = 5'(pp); cfg_q = 3'(qq);
    configure = 1'b1;
    tick();
    configure = 1'b0;
  endtask

  task automatic start_pass();
    tot_wf = 0; tot_wi = 0; busy_cyc = 0; done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      tick();
      if (done_cnt > 0) break;
    end
    chk("done_seen", 32'(done_cnt > 0), 32'd1);
    tick();
  endtask

  task automatic check_pass(input string nm, input int wf, input int wi, input int bc);
    chk({nm, "_wf"}, 32'(tot_wf), 32'(wf));
    chk({nm, "_wi"}, 32'(tot_wi), 32'(wi));
    if (bc >= 0) chk({nm, "_busy_cycles"}, 32'(busy_cyc), 32'(bc));
    chk({nm, "_done_pulses"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; configure = 1'b0; start = 1'b0;
    cfg_s = '0; cfg_f = '0; cfg_u = '0; cfg_p = '0; cfg_q = '0;
    bus.filter_spad_full = 1'b0;
    bus.ifmap_spad_full  = 1'b0;
    tick();
    chk_en = 1;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr_filter", 32'(bus.wr_filter), 32'd0);
    chk("rst_filter_pixel", 32'(bus.filter_pixel), 32'd0);
    reset = 1'b0;
    tick();

    // All counts zero: done the cycle after start
    start_pass();
    chk("zero_done_next", 32'(done), 32'd1);
    wait_done(10);
    check_pass("zero", 0, 0, 1);

    // 1: basic pass
    do_config(3, 4, 1, 2, 2);
    start_pass();
    wait_done(200);
    check_pass("basic", 12, 12, 25);

    // 2: filter spad full for 5 cycles mid-phase
    start_pass();
    for (int k = 0; k < 50 && tot_wf < 4; k++) tick();
    bus.filter_spad_full = 1'b1;
    repeat (5) tick();
    bus.filter_spad_full = 1'b0;
    wait_done(200);
    check_pass("flt_stall", 12, 12, 30);

    // 3: ifm_valid toggling, U=2, F=3
    do_config(3, 3, 2, 2, 2);
    ifm_vmode = 1;
    start_pass();
    wait_done(300);
    ifm_vmode = 0;
    check_pass("ifm_toggle", 12, 14, -1);

    // 4a: F=1 -> only the first window
    do_config(3, 1, 1, 2, 2);
    start_pass();
    wait_done(200);
    check_pass("f_one", 12, 6, 19);

    // 4b: p=0 -> no filter writes
    do_config(3, 4, 1, 0, 2);
    start_pass();
    wait_done(200);
    check_pass("p_zero", 0, 12, 13);

    // 5: start/configure while busy are ignored
    do_config(3, 4, 1, 2, 2);
    start_pass();
    repeat (3) tick();
    cfg_s = 5'd5; configure = 1'b1; start = 1'b1;
    tick();
    configure = 1'b0; start = 1'b0;
    wait_done(200);
    check_pass("busy_ignore", 12, 12, 25);
    start_pass();
    wait_done(200);
    check_pass("cfg_kept", 12, 12, 25);

    // 6: reset during the sliding phase, then replay
    cfg_s = 5'd3;
    start_pass();
    for (int k = 0; k < 100 && tot_wi < 8; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wr_ifmap", 32'(bus.wr_ifmap), 32'd0);
    chk("abort_wr_filter", 32'(bus.wr_filter), 32'd0);
    tick();
    do_config(3, 4, 1, 2, 2);
    start_pass();
    wait_done(200);
    check_pass("replay", 12, 12, 25);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
